// File: rtl/return_addr_stack_pkg.sv
// Shared defaults and constants for the return-address stack.
package return_addr_stack_pkg;

   localparam int unsigned RAS_WIDTH_DEFAULT = 16;
   localparam int unsigned RAS_DEPTH_DEFAULT = 8;

   // Value driven on topOut while the stack holds no entries
   localparam logic [RAS_WIDTH_DEFAULT-1:0] RAS_TOP_EMPTY = '0;

endpackage : return_addr_stack_pkg

// File: rtl/return_addr_stack_if.sv
// Push/pop request and status bundle between the fetch stage and the return-address stack.
interface return_addr_stack_if
   import return_addr_stack_pkg::*;
#(
   parameter int unsigned WIDTH = RAS_WIDTH_DEFAULT,
   parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic             clear;
   logic             push;
   logic [WIDTH-1:0] pushData;
   logic             pop;
   logic [WIDTH-1:0] topOut;
   logic             empty;
   logic             full;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             underflow;

   modport master (
      output clear, push, pushData, pop,
      input  topOut, empty, full, count, overflow, underflow
   );

   modport slave (
      input  clear, push, pushData, pop,
      output topOut, empty, full, count, overflow, underflow
   );

endinterface : return_addr_stack_if

// File: rtl/ras_regfile.sv
// DEPTH x WIDTH storage: one synchronous write port, one combinational read port, no reset.
module ras_regfile
   import return_addr_stack_pkg::*;
#(
   parameter int unsigned WIDTH = RAS_WIDTH_DEFAULT,
   parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : ras_regfile

// File: rtl/return_addr_stack.sv
// Return-address stack: circular buffer of link addresses with sticky overflow/underflow flags.
// Build option RAS_OVERWRITE_EN: a push while full overwrites the oldest entry instead of being dropped.
module return_addr_stack
   import return_addr_stack_pkg::*;
#(
   parameter int unsigned WIDTH = RAS_WIDTH_DEFAULT,
   parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   return_addr_stack_if.slave  bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic             overflow_q,  overflow_d;
   logic             underflow_q, underflow_d;

   logic             is_empty;
   logic             is_full;
   logic             we;
   logic [PTR_W-1:0] waddr;
   logic [WIDTH-1:0] rdata;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);

   // Next-state: clear beats push/pop; push+pop on a non-empty stack replaces the top in place
   always_comb begin
      top_ptr_d   = top_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      we          = 1'b0;
      waddr       = top_ptr_q + PTR_ONE;

      if (bus.clear) begin
         top_ptr_d   = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else if (bus.push && bus.pop && !is_empty) begin
         we    = 1'b1;
         waddr = top_ptr_q;
      end else if (bus.push) begin
         if (bus.pop) begin
            underflow_d = 1'b1;
         end
         if (is_full) begin
            overflow_d = 1'b1;
`ifdef RAS_OVERWRITE_EN
            we        = 1'b1;
            top_ptr_d = top_ptr_q + PTR_ONE;
`else
            we        = 1'b0;
`endif
         end else begin
            we        = 1'b1;
            top_ptr_d = top_ptr_q + PTR_ONE;
            count_d   = count_q + CNT_ONE;
         end
      end else if (bus.pop) begin
         if (is_empty) begin
            underflow_d = 1'b1;
         end else begin
            top_ptr_d = top_ptr_q - PTR_ONE;
            count_d   = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_ptr_q   <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         top_ptr_q   <= top_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   ras_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (bus.pushData),
      .raddr_i (top_ptr_q),
      .rdata_o (rdata)
   );

   // topOut comes from state only; a push is never forwarded within its own cycle
   assign bus.topOut    = is_empty ? WIDTH'(RAS_TOP_EMPTY) : rdata;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule : return_addr_stack
